alu_apb_regif: RTL and testbench

- APB completer that gives bus access to the ALU datapath: operand, control, result and status registers, plus the ALU execution FSM behind them.
- Responds to the psel/penable/pwrite/paddr/pwdata initiator traffic driven by the ALU bench and the system bus.
- Single-cycle logic/arith ops plus an iterative 32-cycle shift-add multiply; completion reported via sticky status.

---
 rtl/alu_apb_if.sv | 24 ++
 rtl/alu_apb_regif.sv | 163 ++++++++++++++++
 tb/tb_alu_apb_regif.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_apb_if.sv
// APB bus bundle between an initiator and the ALU register block.
interface alu_apb_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/alu_apb_regif.sv
// APB register front end for the ALU with a 32-cycle shift-add multiply.
// Defining ALU_IRQ_EN adds the irq output and the IRQ_EN register at 0x14.
module alu_apb_regif #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic     clk,
    input  logic     reset_n,
    alu_apb_if.slave bus
`ifdef ALU_IRQ_EN
    ,
    output logic     irq
`endif
);
    typedef enum logic [1:0] {IDLE, EXEC, MUL} state_t;

`ifdef ALU_IRQ_EN
    localparam logic [2:0] LAST = 3'd5;
    logic irq_en;
`else
    localparam logic [2:0] LAST = 3'd4;
`endif

    state_t            state;
    logic [DATA_W-1:0] opa, opb, result;
    logic [DATA_W-1:0] ma, mb, acc;
    logic [3:0]        opcode;
    logic [4:0]        cnt;
    logic              carry, zero, done;
    logic              busy, mapped, err, access, commit;
    logic [2:0]        idx;
    logic [DATA_W-1:0] rdata, ex_res, mul_res;
    logic              ex_c;

    assign busy   = (state != IDLE);
    assign idx    = bus.paddr[4:2];
    assign mapped = (bus.paddr[ADDR_W-1:5] == '0)
                  && (bus.paddr[1:0] == 2'b00)
                  && (idx <= LAST);
    assign err    = !mapped
                  || (bus.pwrite && idx == 3'd3)
                  || (bus.pwrite && busy && idx <= 3'd2);
    assign access = bus.psel && bus.penable && !bus.pready;
    // pslverr is still held from the wait state, so it gates the commit
    assign commit = bus.psel && bus.penable && bus.pready
                  && bus.pwrite && !bus.pslverr;
    assign mul_res = acc + (mb[0] ? ma : '0);

    always_comb begin
        rdata = '0;
        case (idx)
            3'd0:    rdata = opa;
            3'd1:    rdata = opb;
            3'd2:    rdata = DATA_W'(opcode);
            3'd3:    rdata = result;
            3'd4:    rdata = DATA_W'({zero, carry, done, busy});
`ifdef ALU_IRQ_EN
            3'd5:    rdata = DATA_W'(irq_en);
`endif
            default: rdata = '0;
        endcase
    end

    always_comb begin
        ex_res = '0;
        ex_c   = 1'b0;
        case (opcode)
            4'd0: {ex_c, ex_res} = {1'b0, opa} + {1'b0, opb};
            4'd1: begin
                ex_res = opa - opb;
                ex_c   = (opa < opb);
            end
            4'd2: ex_res = opa & opb;
            4'd3: ex_res = opa | opb;
            4'd4: ex_res = opa ^ opb;
            4'd5: ex_res = opa << opb[4:0];
            4'd6: ex_res = opa >> opb[4:0];
            4'd7: ex_res = $signed(opa) >>> opb[4:0];
            default: ex_res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            opa         <= '0;
            opb         <= '0;
            result      <= '0;
            ma          <= '0;
            mb          <= '0;
            acc         <= '0;
            opcode      <= '0;
            cnt         <= '0;
            carry       <= 1'b0;
            zero        <= 1'b0;
            done        <= 1'b0;
            bus.pready  <= 1'b0;
            bus.prdata  <= '0;
            bus.pslverr <= 1'b0;
`ifdef ALU_IRQ_EN
            irq_en      <= 1'b0;
            irq         <= 1'b0;
`endif
        end else begin
            bus.pready  <= 1'b0;
            bus.prdata  <= '0;
            bus.pslverr <= 1'b0;
            if (access) begin
                bus.pready  <= 1'b1;
                bus.pslverr <= err;
                bus.prdata  <= (err || bus.pwrite) ? '0 : rdata;
            end
            if (commit) begin
                case (idx)
                    3'd0: opa <= bus.pwdata;
                    3'd1: opb <= bus.pwdata;
                    3'd2: begin
                        opcode <= bus.pwdata[3:0];
                        if (bus.pwdata[8]) begin
                            state <= (bus.pwdata[3:0] == 4'd8) ? MUL : EXEC;
                            ma    <= opa;
                            mb    <= opb;
                            acc   <= '0;
                            cnt   <= '0;
                        end
                    end
                    3'd4: if (bus.pwdata[1]) done <= 1'b0;
`ifdef ALU_IRQ_EN
                    3'd5: irq_en <= bus.pwdata[0];
`endif
                    default: ;
                endcase
            end
            // completion comes after the W1C so a same-edge set wins
            case (state)
                EXEC: begin
                    result <= ex_res;
                    carry  <= ex_c;
                    zero   <= (ex_res == '0);
                    done   <= 1'b1;
                    state  <= IDLE;
                end
                MUL: begin
                    acc <= mul_res;
                    ma  <= ma << 1;
                    mb  <= mb >> 1;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31) begin
                        result <= mul_res;
                        carry  <= 1'b0;
                        zero   <= (mul_res == '0);
                        done   <= 1'b1;
                        state  <= IDLE;
                    end
                end
                default: ;
            endcase
`ifdef ALU_IRQ_EN
            irq <= done & irq_en;
`endif
        end
    end
endmodule

// File: tb/tb_alu_apb_regif.sv
// Bench for alu_apb_regif: vector table, corner sequences, random ops
// against an arithmetic reference model.
module tb_alu_apb_regif;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    alu_apb_if #(.ADDR_W(32), .DATA_W(32)) apb ();

`ifdef ALU_IRQ_EN
    logic irq;
`endif

    alu_apb_regif #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (apb)
`ifdef ALU_IRQ_EN
        ,
        .irq     (irq)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic        c;
        logic        z;
    } vec_t;

    vec_t vt[13];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Called just after a clock edge; returns just after the commit edge.
    task automatic xfer(input logic wr, input logic [31:0] a,
                        input logic [31:0] d,
                        output logic [31:0] rd, output logic er);
        apb.psel    = 1'b1;
        apb.penable = 1'b0;
        apb.pwrite  = wr;
        apb.paddr   = a;
        apb.pwdata  = d;
        @(posedge clk); #1;
        apb.penable = 1'b1;
        chk("pready_wait", {31'b0, apb.pready}, 32'd0);
        @(posedge clk); #1;
        chk("pready_done", {31'b0, apb.pready}, 32'd1);
        rd = apb.prdata;
        er = apb.pslverr;
        @(posedge clk); #1;
        chk("pready_drop", {31'b0, apb.pready}, 32'd0);
        apb.psel    = 1'b0;
        apb.penable = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic exp_err, input string name);
        logic [31:0] rd;
        logic        er;
        xfer(1'b1, a, d, rd, er);
        chk({name, "_err"}, {31'b0, er}, {31'b0, exp_err});
    endtask

    task automatic rd_chk(input logic [31:0] a, input logic [31:0] exp,
                          input string name);
        logic [31:0] rd;
        logic        er;
        xfer(1'b0, a, 32'h0, rd, er);
        chk(name, rd, exp);
        chk({name, "_err"}, {31'b0, er}, 32'd0);
    endtask

    task automatic rd_bad(input logic [31:0] a, input string name);
        logic [31:0] rd;
        logic        er;
        xfer(1'b0, a, 32'h0, rd, er);
        chk({name, "_err"}, {31'b0, er}, 32'd1);
        chk({name, "_data"}, rd, 32'd0);
    endtask

    task automatic rd_val(input logic [31:0] a, output logic [31:0] v);
        logic er;
        xfer(1'b0, a, 32'h0, v, er);
        chk("rd_val_err", {31'b0, er}, 32'd0);
    endtask

    function automatic void model(input logic [3:0] op,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic c);
        logic [32:0] s;
        logic [63:0] p;
        c = 1'b0;
        case (op)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0];
                c = s[32];
            end
            4'd1: begin
                r = a - b;
                c = (a < b);
            end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: r = $signed(a) >>> b[4:0];
            4'd8: begin
                p = {32'd0, a} * {32'd0, b};
                r = p[31:0];
            end
            default: r = 32'd0;
        endcase
    endfunction

    initial begin
        logic [31:0] v, exp_r;
        logic        exp_c;

        vt[0]  = '{4'd0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1};
        vt[1]  = '{4'd1, 32'h00000005, 32'h00000007, 32'hFFFFFFFE, 1'b1, 1'b0};
        vt[2]  = '{4'd2, 32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 1'b0, 1'b0};
        vt[3]  = '{4'd3, 32'h12340000, 32'h00005678, 32'h12345678, 1'b0, 1'b0};
        vt[4]  = '{4'd4, 32'hAAAA5555, 32'hAAAA5555, 32'h00000000, 1'b0, 1'b1};
        vt[5]  = '{4'd5, 32'h00000001, 32'h0000001F, 32'h80000000, 1'b0, 1'b0};
        vt[6]  = '{4'd6, 32'h80000000, 32'h00000024, 32'h08000000, 1'b0, 1'b0};
        vt[7]  = '{4'd7, 32'h80000000, 32'h00000004, 32'hF8000000, 1'b0, 1'b0};
        vt[8]  = '{4'd8, 32'h00012345, 32'h00000100, 32'h01234500, 1'b0, 1'b0};
        vt[9]  = '{4'd8, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0};
        vt[10] = '{4'd9, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 1'b0, 1'b1};
        vt[11] = '{4'd0, 32'h00000007, 32'h00000008, 32'h0000000F, 1'b0, 1'b0};
        vt[12] = '{4'd1, 32'h00000007, 32'h00000007, 32'h00000000, 1'b0, 1'b1};

        apb.psel    = 1'b0;
        apb.penable = 1'b0;
        apb.pwrite  = 1'b0;
        apb.paddr   = '0;
        apb.pwdata  = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pready", {31'b0, apb.pready}, 32'd0);
        chk("reset_prdata", apb.prdata, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i <= 4; i++)
            rd_chk(32'(i * 4), 32'd0, $sformatf("reset_reg%0d", i));

        // Table vectors; each result checked along with flags and W1C
        for (int i = 0; i < 13; i++) begin
            wr(32'h00, vt[i].a, 1'b0, "vec_opa");
            wr(32'h04, vt[i].b, 1'b0, "vec_opb");
            wr(32'h08, 32'h100 | 32'(vt[i].op), 1'b0, "vec_ctrl");
            if (vt[i].op == 4'd8) begin
                repeat (32) @(posedge clk);
                #1;
            end
            rd_chk(32'h10, {28'd0, vt[i].z, vt[i].c, 2'b10},
                   $sformatf("vec%0d_status", i));
            rd_chk(32'h0C, vt[i].res, $sformatf("vec%0d_result", i));
            rd_chk(32'h08, 32'(vt[i].op), $sformatf("vec%0d_ctrl", i));
            wr(32'h10, 32'h2, 1'b0, "vec_w1c");
            rd_chk(32'h10, {28'd0, vt[i].z, vt[i].c, 2'b00},
                   $sformatf("vec%0d_cleared", i));
        end

        // MUL busy window; blocked operand write
        wr(32'h00, 32'h00012345, 1'b0, "m1_opa");
        wr(32'h04, 32'h00000100, 1'b0, "m1_opb");
        wr(32'h08, 32'h108, 1'b0, "m1_start");
        wr(32'h00, 32'h0000DEAD, 1'b1, "m1_busy_opa");
        repeat (27) @(posedge clk);
        #1;
        rd_val(32'h10, v);
        chk("m1_busy_late", {30'd0, v[1:0]}, 32'h1);
        rd_chk(32'h00, 32'h00012345, "m1_opa_kept");
        rd_chk(32'h0C, 32'h01234500, "m1_result");
        rd_chk(32'h10, 32'h2, "m1_status");

        // DONE clear colliding with MUL completion: set wins
        wr(32'h10, 32'h2, 1'b0, "m2_clr");
        wr(32'h08, 32'h108, 1'b0, "m2_start");
        repeat (29) @(posedge clk);
        #1;
        wr(32'h10, 32'h2, 1'b0, "m2_clr_same_edge");
        rd_chk(32'h10, 32'h2, "m2_done_wins");

        // BUSY ends exactly at the 32nd edge
        wr(32'h10, 32'h2, 1'b0, "m3_clr");
        wr(32'h08, 32'h108, 1'b0, "m3_start");
        repeat (31) @(posedge clk);
        #1;
        rd_chk(32'h10, 32'h2, "m3_idle_at_32");

        // Error responses leave state alone
        rd_bad(32'h02, "bad_align");
        rd_bad(32'h18, "bad_high");
        rd_bad(32'h14, "bad_0x14");
        rd_bad(32'h80000000, "bad_upper");
        wr(32'h0C, 32'h55, 1'b1, "bad_wr_result");
        rd_chk(32'h0C, 32'h01234500, "result_kept");

        // START=0 only updates the opcode
        wr(32'h08, 32'h3, 1'b0, "nostart_ctrl");
        rd_chk(32'h08, 32'h3, "nostart_opcode");
        rd_chk(32'h10, 32'h2, "nostart_status");
        rd_chk(32'h0C, 32'h01234500, "nostart_result");

        // Reset in the middle of a multiply
        wr(32'h08, 32'h108, 1'b0, "rst_start");
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #3;
        chk("rst_pready", {31'b0, apb.pready}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        rd_chk(32'h10, 32'h0, "rst_status");
        rd_chk(32'h0C, 32'h0, "rst_result");
        rd_chk(32'h00, 32'h0, "rst_opa");
        wr(32'h00, 32'd2, 1'b0, "post_opa");
        wr(32'h04, 32'd3, 1'b0, "post_opb");
        wr(32'h08, 32'h100, 1'b0, "post_add");
        rd_chk(32'h0C, 32'd5, "post_result");

        // Randomised operations against the reference model
        for (int n = 0; n < 40; n++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            op = 4'($urandom_range(0, 15));
            a  = $urandom;
            b  = (n % 3 == 0) ? a : $urandom;
            if (n % 4 == 1) b = 32'($urandom_range(0, 40));
            model(op, a, b, exp_r, exp_c);
            wr(32'h00, a, 1'b0, "rnd_opa");
            wr(32'h04, b, 1'b0, "rnd_opb");
            wr(32'h08, 32'h100 | 32'(op), 1'b0, "rnd_ctrl");
            repeat (32) @(posedge clk);
            #1;
            rd_chk(32'h0C, exp_r, $sformatf("rnd%0d_op%0d_result", n, op));
            rd_chk(32'h10, {28'd0, exp_r == 32'd0, exp_c, 2'b10},
                   $sformatf("rnd%0d_op%0d_status", n, op));
            wr(32'h10, 32'h2, 1'b0, "rnd_w1c");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
